// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction-memory loader/arbiter.
package imem_pkg;

  localparam int unsigned InstrLen = 20;
  localparam int unsigned Addr     = 5;
  localparam int unsigned ProgLen  = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } imem_state_e;

endpackage

// File: rtl/imem_loader_arb.sv
// Loads a program into instruction memory, then arbitrates fetch reads against it.
// Writes only happen in LOAD and reads only in RUN, so the memory ports never collide.
module imem_loader_arb
  import imem_pkg::*;
#(
  parameter int unsigned INSTR_LEN = InstrLen,
  parameter int unsigned ADDR      = Addr,
  parameter int unsigned PROG_LEN  = ProgLen
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  input  logic [INSTR_LEN-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  input  logic                 fetch_req,
  input  logic [ADDR-1:0]      fetch_addr,
  output logic                 fetch_gnt,
  output logic                 fetch_valid,
  output logic [INSTR_LEN-1:0] fetch_data,
  output logic                 fetch_err,
  output logic                 mem_wr_en,
  output logic [ADDR-1:0]      mem_wr_addr,
  output logic [INSTR_LEN-1:0] mem_wr_data,
  output logic                 mem_rd_en,
  output logic [ADDR-1:0]      mem_rd_addr,
  input  logic [INSTR_LEN-1:0] mem_rd_data,
  output logic [ADDR:0]        prog_cnt,
  output logic                 load_ovf,
  output logic                 ready
);

  localparam logic [ADDR-1:0] LastPtr = ADDR'(PROG_LEN - 1);

  imem_state_e     state_q;
  logic [ADDR-1:0] wr_ptr_q;
  logic [ADDR:0]   prog_cnt_q;
  logic            load_ovf_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic            rsp_rd_q;

  logic accept;
  logic in_range;
  logic at_last;

  always_comb begin
    ld_ready    = (state_q == StLoad) && !ld_start;
    accept      = ld_valid && ld_ready;
    at_last     = (wr_ptr_q == LastPtr);
    mem_wr_en   = accept;
    mem_wr_addr = wr_ptr_q;
    mem_wr_data = ld_data;

    fetch_gnt   = fetch_req && (state_q == StRun) && !ld_start;
    in_range    = ({1'b0, fetch_addr} < prog_cnt_q);
    mem_rd_en   = fetch_gnt && in_range;
    mem_rd_addr = fetch_addr;

    // Read data is only passed through on a real read, otherwise the response is forced to 0.
    fetch_valid = rsp_valid_q;
    fetch_err   = rsp_err_q;
    fetch_data  = rsp_rd_q ? mem_rd_data : '0;

    prog_cnt    = prog_cnt_q;
    load_ovf    = load_ovf_q;
    ready       = (state_q == StRun);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      prog_cnt_q  <= '0;
      load_ovf_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      rsp_valid_q <= fetch_gnt;
      rsp_err_q   <= fetch_gnt && !in_range;
      rsp_rd_q    <= mem_rd_en;

      // ld_start wins from any state and restarts the load from an empty program.
      if (ld_start) begin
        state_q    <= StLoad;
        wr_ptr_q   <= '0;
        prog_cnt_q <= '0;
        load_ovf_q <= 1'b0;
      end else if (accept) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        prog_cnt_q <= prog_cnt_q + 1'b1;
        if (ld_last || at_last) begin
          state_q <= StRun;
        end
        if (!ld_last && at_last) begin
          load_ovf_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader_arb.sv
// Self-checking bench for imem_loader_arb with a behavioural instruction memory beside it.
module tb_imem_loader_arb;

  localparam int unsigned IL = 20;
  localparam int unsigned AW = 5;
  localparam int unsigned PL = 32;

  typedef struct packed {
    logic          err;
    logic [IL-1:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [IL-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt;
  logic          fetch_valid;
  logic [IL-1:0] fetch_data;
  logic          fetch_err;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [IL-1:0] mem_wr_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [IL-1:0] mem_rd_data;
  logic [AW:0]   prog_cnt;
  logic          load_ovf;
  logic          ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [IL-1:0] mem  [PL];
  logic [IL-1:0] gold [PL];
  int            exp_cnt = 0;
  rsp_t          exp_q [$];
  logic [AW-1:0] fetch_addrs [$];

  always #5 clk = ~clk;

  imem_loader_arb #(
    .INSTR_LEN (IL),
    .ADDR      (AW),
    .PROG_LEN  (PL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .prog_cnt    (prog_cnt),
    .load_ovf    (load_ovf),
    .ready       (ready)
  );

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic test_reset();
    fetch_req = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({ready, ld_ready, fetch_valid, fetch_err, fetch_gnt, mem_wr_en, mem_rd_en, load_ovf}
        !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000000",
               {ready, ld_ready, fetch_valid, fetch_err, fetch_gnt, mem_wr_en, mem_rd_en,
                load_ovf});
    end
    n_cmp++;
    if ({prog_cnt, fetch_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_counts: prog_cnt=%0d fetch_data=%h want 0/0", prog_cnt, fetch_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (fetch_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_gnt: got %b want 0", fetch_gnt);
    end
    fetch_req = 1'b0;
  endtask

  // Starts a load (with a fetch attempt in the start cycle) and streams n words.
  task automatic load_prog(input int n, input bit with_last, input int base);
    bit done = 1'b0;
    bit last_acc = 1'b0;
    int acc = 0;
    int obs_wr = 0;
    @(posedge clk); #1;
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = '1; fetch_req = 1'b1; fetch_addr = '0;
    @(negedge clk);
    n_cmp++;
    if ({ld_ready, mem_wr_en, fetch_gnt, mem_rd_en} !== 4'b0) begin
      n_bad++;
      $display("FAIL load_start_quiet: got %b want 0000",
               {ld_ready, mem_wr_en, fetch_gnt, mem_rd_en});
    end
    @(posedge clk); #1;
    ld_start = 1'b0; fetch_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = IL'(base + i);
      ld_last  = with_last && (i == n - 1);
      @(negedge clk);
      if (mem_wr_en) obs_wr++;
      n_cmp++;
      if (!done) begin
        if ({ld_ready, mem_wr_en, mem_wr_addr, mem_wr_data} !== {2'b11, AW'(i), ld_data}) begin
          n_bad++;
          $display("FAIL load_word%0d: rdy/we/addr/data=%b/%b/%0d/%h want 1/1/%0d/%h",
                   i, ld_ready, mem_wr_en, mem_wr_addr, mem_wr_data, i, ld_data);
        end
        gold[i]  = ld_data;
        acc++;
        last_acc = ld_last;
        done     = ld_last || (i == PL - 1);
      end else if ({ld_ready, mem_wr_en} !== 2'b00) begin
        n_bad++;
        $display("FAIL load_ignored%0d: rdy/we=%b/%b want 0/0", i, ld_ready, mem_wr_en);
      end
      @(posedge clk); #1;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    exp_cnt = acc;
    @(negedge clk);
    n_cmp++;
    if ({prog_cnt, ready, load_ovf} !== {(AW + 1)'(acc), done, done && !last_acc}) begin
      n_bad++;
      $display("FAIL load_result: cnt/ready/ovf=%0d/%b/%b want %0d/%b/%b",
               prog_cnt, ready, load_ovf, acc, done, done && !last_acc);
    end
    n_cmp++;
    if (obs_wr != acc) begin
      n_bad++;
      $display("FAIL load_writes: got %0d want %0d", obs_wr, acc);
    end
  endtask

  // Issues fetch_addrs back to back; responses are scored one cycle behind their grant.
  task automatic run_fetches(input string tag);
    int   n = fetch_addrs.size();
    rsp_t e;
    for (int i = 0; i <= n; i++) begin
      logic [AW-1:0] a = '0;
      bit            rd = 1'b0;
      @(posedge clk); #1;
      if (i < n) begin
        a          = fetch_addrs[i];
        rd         = (int'(a) < exp_cnt);
        fetch_req  = 1'b1;
        fetch_addr = a;
        exp_q.push_back(rd ? rsp_t'{1'b0, gold[a]} : rsp_t'{1'b1, '0});
      end else begin
        fetch_req = 1'b0;
      end
      @(negedge clk);
      if (i < n) begin
        n_cmp++;
        if ({fetch_gnt, mem_rd_en} !== {1'b1, rd} || (rd && mem_rd_addr !== a)) begin
          n_bad++;
          $display("FAIL %s_gnt%0d: gnt/rd_en/rd_addr=%b/%b/%0d want 1/%b/%0d",
                   tag, i, fetch_gnt, mem_rd_en, mem_rd_addr, rd, a);
        end
      end
      n_cmp++;
      if (i == 0) begin
        if ({fetch_valid, fetch_err, fetch_data} !== '0) begin
          n_bad++;
          $display("FAIL %s_idle_rsp: v/err/data=%b/%b/%h want 0/0/0",
                   tag, fetch_valid, fetch_err, fetch_data);
        end
      end else begin
        e = exp_q.pop_front();
        if ({fetch_valid, fetch_err, fetch_data} !== {1'b1, e.err, e.data}) begin
          n_bad++;
          $display("FAIL %s_rsp%0d: v/err/data=%b/%b/%h want 1/%b/%h",
                   tag, i - 1, fetch_valid, fetch_err, fetch_data, e.err, e.data);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_leftover: got %0d pending want 0", tag, exp_q.size());
      exp_q.delete();
    end
    fetch_addrs.delete();
  endtask

  task automatic test_load4();
    load_prog(4, 1'b1, 1);
  endtask

  task automatic test_fetch_single();
    fetch_addrs = '{5'd2};
    run_fetches("single");
  endtask

  task automatic test_back_to_back();
    fetch_addrs = '{5'd0, 5'd1, 5'd2, 5'd3};
    run_fetches("b2b");
  endtask

  task automatic test_out_of_range();
    fetch_addrs = '{5'd7};
    run_fetches("oor");
    fetch_addrs = '{5'd1, 5'd4, 5'd3, 5'd31, 5'd0};
    run_fetches("mix");
  endtask

  task automatic test_restart();
    load_prog(2, 1'b0, 'h10);
    load_prog(4, 1'b1, 'h21);
    fetch_addrs = '{5'd3, 5'd0};
    run_fetches("restart");
  endtask

  task automatic test_overflow();
    load_prog(33, 1'b0, 'h100);
    fetch_addrs = '{5'd31, 5'd0, 5'd16};
    run_fetches("ovf");
  endtask

  task automatic test_reset_mid_fetch();
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 5'd1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    n_cmp++;
    if (fetch_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midfetch_valid: got %b want 1", fetch_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({fetch_valid, fetch_err, fetch_data, ready} !== '0) begin
      n_bad++;
      $display("FAIL midfetch_discard: v/err/data/ready=%b/%b/%h/%b want 0/0/0/0",
               fetch_valid, fetch_err, fetch_data, ready);
    end
    @(posedge clk); #1 rst = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_reset_mid_load();
    @(posedge clk); #1 ld_start = 1'b1;
    @(posedge clk); #1 ld_start = 1'b0; ld_valid = 1'b1; ld_data = 'h55;
    @(posedge clk); #1 ld_data = 'h66;
    @(posedge clk); #1 ld_data = 'h77;
    n_cmp++;
    if (prog_cnt !== 6'd2) begin
      n_bad++;
      $display("FAIL midload_cnt: got %0d want 2", prog_cnt);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({prog_cnt, ready, ld_ready, mem_wr_en, load_ovf} !== '0) begin
      n_bad++;
      $display("FAIL midload_reset: cnt/ready/ldrdy/we/ovf=%0d/%b/%b/%b/%b want 0/0/0/0/0",
               prog_cnt, ready, ld_ready, mem_wr_en, load_ovf);
    end
    @(posedge clk); #1;
    rst = 1'b1; ld_valid = 1'b0; fetch_req = 1'b1; fetch_addr = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({fetch_gnt, fetch_valid, mem_rd_en} !== 3'b0) begin
        n_bad++;
        $display("FAIL midload_nognt%0d: gnt/v/rd=%b/%b/%b want 0/0/0",
                 i, fetch_gnt, fetch_valid, mem_rd_en);
      end
    end
    fetch_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load4();
    test_fetch_single();
    test_back_to_back();
    test_out_of_range();
    test_restart();
    test_overflow();
    test_reset_mid_fetch();
    test_reset_mid_load();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
